// File: rtl/shifter_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality helper
// for the sequential shifter.
package shifter_pkg;

  localparam logic [2:0] SH_ASL = 3'b000;
  localparam logic [2:0] SH_ASR = 3'b001;
  localparam logic [2:0] SH_LSL = 3'b010;
  localparam logic [2:0] SH_LSR = 3'b011;
  localparam logic [2:0] SH_ROL = 3'b100;
  localparam logic [2:0] SH_ROR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= SH_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational 1-bit step of a shift or rotate, with the bit shifted
// out and a flag telling whether the MSB changed across the step.
module shift_step
  import shifter_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] q_i,
  input  logic [2:0]       op_i,
  output logic [NBITS-1:0] q_o,
  output logic             c_o,
  output logic             sgn_chg_o
);

  always_comb begin
    q_o = q_i;
    c_o = 1'b0;
    case (op_i)
      SH_ASL, SH_LSL: begin
        q_o = {q_i[NBITS-2:0], 1'b0};
        c_o = q_i[NBITS-1];
      end
      SH_ASR: begin
        q_o = {q_i[NBITS-1], q_i[NBITS-1:1]};
        c_o = q_i[0];
      end
      SH_LSR: begin
        q_o = {1'b0, q_i[NBITS-1:1]};
        c_o = q_i[0];
      end
      SH_ROL: begin
        q_o = {q_i[NBITS-2:0], q_i[NBITS-1]};
        c_o = q_i[NBITS-1];
      end
      SH_ROR: begin
        q_o = {q_i[0], q_i[NBITS-1:1]};
        c_o = q_i[0];
      end
      default: begin
        q_o = q_i;
        c_o = 1'b0;
      end
    endcase
  end

  assign sgn_chg_o = q_o[NBITS-1] ^ q_i[NBITS-1];

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: accepts an operation in IDLE, applies one bit per
// cycle in SHIFT, and pulses DONE for one cycle in FIN.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int AMTW  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [NBITS-1:0] A,
  input  logic [2:0]       OpCode,
  input  logic [AMTW-1:0]  AMT,
  output logic [NBITS-1:0] Q,
  output logic             C,
  output logic             V,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state_q, state_d;
  logic [NBITS-1:0] q_q, q_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic [AMTW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic [NBITS-1:0] step_q;
  logic             step_c;
  logic             step_sgn;

  shift_step #(
    .NBITS(NBITS)
  ) u_step (
    .q_i      (q_q),
    .op_i     (op_q),
    .q_o      (step_q),
    .c_o      (step_c),
    .sgn_chg_o(step_sgn)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    c_d     = c_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          c_d     = 1'b0;
          v_d     = 1'b0;
          op_d    = OpCode;
          cnt_d   = '0;
          state_d = ST_FIN;
          if (!op_legal(OpCode)) begin
            q_d = '0;
          end else begin
            q_d = A;
            if (AMT != '0) begin
              cnt_d   = AMT;
              state_d = ST_SHIFT;
            end
          end
        end
      end
      ST_SHIFT: begin
        q_d   = step_q;
        c_d   = step_c;
        cnt_d = cnt_q - AMTW'(1);
        // V is sticky: only ever set here, cleared on the next accepted START.
        if (op_q == SH_ASL && step_sgn) begin
          v_d = 1'b1;
        end
        if (cnt_q == AMTW'(1)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
      op_q    <= SH_ASL;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      c_q     <= c_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign Q    = q_q;
  assign C    = c_q;
  assign V    = v_q;
  assign BUSY = (state_q == ST_SHIFT);
  assign DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (NBITS=8, AMTW=4): a vector table plus
// hand-written sequences for ignored START, back-to-back and reset abort.
module tb_seq_shifter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic [7:0] A;
  logic [2:0] OpCode;
  logic [3:0] AMT;
  logic [7:0] Q;
  logic       C, V, BUSY, DONE;

  int total  = 0;
  int passed = 0;

  seq_shifter #(.NBITS(8), .AMTW(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .OpCode(OpCode),
    .AMT(AMT), .Q(Q), .C(C), .V(V), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [3:0] amt;
    logic [7:0] q;
    logic       c;
    logic       v;
    int         lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic launch(input logic [2:0] op, input logic [7:0] a, input logic [3:0] amt);
    @(negedge CLK);
    START = 1'b1; OpCode = op; A = a; AMT = amt;
    @(posedge CLK);
    #1;
    START = 1'b0;
    // Scramble operands so a design that re-reads them would be caught.
    A = 8'($urandom); OpCode = 3'($urandom); AMT = 4'($urandom);
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [7:0] eq,
                           input logic ec, input logic ev);
    int  k = 0;
    int  busy_cnt = 0;
    bit  seen = 0;
    while (!seen && k < 40) begin
      @(negedge CLK);
      k++;
      if (DONE === 1'b1) seen = 1;
      else if (BUSY === 1'b1) busy_cnt++;
    end
    check({nm, " latency"}, seen ? k : -1, lat);
    check({nm, " busy cycles"}, busy_cnt, lat - 1);
    check({nm, " Q"}, Q, eq);
    check({nm, " C"}, C, ec);
    check({nm, " V"}, V, ev);
    @(negedge CLK);
    check({nm, " DONE one cycle"}, {BUSY, DONE}, 2'b00);
    check({nm, " Q held"}, {Q, C, V}, {eq, ec, ev});
  endtask

  initial begin
    int k;
    int dones;
    int k1;
    int k2;

    vecs[0]  = '{3'd0, 8'h41, 4'd1,  8'h82, 1'b0, 1'b1, 2};
    vecs[1]  = '{3'd1, 8'h90, 4'd3,  8'hF2, 1'b0, 1'b0, 4};
    vecs[2]  = '{3'd3, 8'hFF, 4'd8,  8'h00, 1'b1, 1'b0, 9};
    vecs[3]  = '{3'd4, 8'h81, 4'd9,  8'h03, 1'b1, 1'b0, 10};
    vecs[4]  = '{3'd5, 8'h01, 4'd0,  8'h01, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd7, 8'h5A, 4'd5,  8'h00, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd2, 8'h81, 4'd1,  8'h02, 1'b1, 1'b0, 2};
    vecs[7]  = '{3'd0, 8'h81, 4'd1,  8'h02, 1'b1, 1'b1, 2};
    vecs[8]  = '{3'd0, 8'h20, 4'd2,  8'h80, 1'b0, 1'b1, 3};
    vecs[9]  = '{3'd0, 8'hC0, 4'd3,  8'h00, 1'b0, 1'b1, 4};
    vecs[10] = '{3'd1, 8'h7F, 4'd15, 8'h00, 1'b0, 1'b0, 16};
    vecs[11] = '{3'd5, 8'h01, 4'd1,  8'h80, 1'b1, 1'b0, 2};
    vecs[12] = '{3'd2, 8'hFF, 4'd10, 8'h00, 1'b0, 1'b0, 11};
    vecs[13] = '{3'd5, 8'h96, 4'd8,  8'h96, 1'b1, 1'b0, 9};
    vecs[14] = '{3'd6, 8'hFF, 4'd0,  8'h00, 1'b0, 1'b0, 1};
    vecs[15] = '{3'd1, 8'h80, 4'd15, 8'hFF, 1'b1, 1'b0, 16};

    RST_N = 1'b0; START = 1'b0; A = '0; OpCode = '0; AMT = '0;
    repeat (2) @(negedge CLK);
    check("reset outputs", {Q, C, V, BUSY, DONE}, 12'h000);
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle after reset", {Q, C, V, BUSY, DONE}, 12'h000);

    for (int i = 0; i < 16; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].amt);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].q, vecs[i].c, vecs[i].v);
    end

    // START pulsed during SHIFT must be dropped, not queued.
    launch(3'd3, 8'h80, 4'd4);
    dones = 0; k1 = -1;
    for (k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) begin START = 1'b1; OpCode = 3'd4; A = 8'hFF; AMT = 4'd1; end
      if (k == 2) START = 1'b0;
      if (DONE === 1'b1) begin
        dones++;
        if (k1 < 0) begin
          k1 = k;
          check("ignored start Q", {Q, C, V}, {8'h08, 1'b0, 1'b0});
        end
      end
    end
    check("ignored start latency", k1, 5);
    check("ignored start done count", dones, 1);

    // START held high: back-to-back operations AMT+2 cycles apart.
    @(negedge CLK);
    START = 1'b1; OpCode = 3'd3; A = 8'h04; AMT = 4'd2;
    @(posedge CLK);
    k1 = -1; k2 = -1;
    for (k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        check("held start Q", {Q, C}, {8'h01, 1'b0});
        if (k1 < 0) k1 = k;
        else if (k2 < 0) k2 = k;
      end
    end
    START = 1'b0;
    check("held start first done", k1, 3);
    check("held start spacing", k2 - k1, 4);
    repeat (6) @(negedge CLK);

    // Asynchronous reset mid-SHIFT aborts with no DONE.
    launch(3'd4, 8'hAA, 4'd6);
    repeat (2) @(negedge CLK);
    check("pre-reset busy", BUSY, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("async reset outputs", {Q, C, V, BUSY, DONE}, 12'h000);
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    check("no done after abort", dones, 0);

    // START held through reset is accepted on the first edge after release.
    @(negedge CLK);
    RST_N = 1'b0;
    START = 1'b1; OpCode = 3'd0; A = 8'h41; AMT = 4'd1;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done("first start after reset", 2, 8'h82, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter NBITS, default 8: operand width, legal range 2..64.
REQ-002 SHALL have parameter AMTW, default 4: shift-amount width, legal range 1..8.
REQ-003 SHALL have port CLK  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port A  input  NBITS  operand, captured on the accepted START.
REQ-007 SHALL have port OpCode  input  3  operation, captured on the accepted START.
REQ-008 SHALL have port AMT  input  AMTW  shift count, captured on the accepted START.
REQ-009 SHALL have port Q  output  NBITS  result register.
REQ-010 SHALL have port C  output  1  carry: the last bit shifted or rotated out.
REQ-011 SHALL have port V  output  1  sticky overflow: the sign changed during any ASL step.
REQ-012 SHALL have port BUSY  output  1  high in SHIFT state.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse marking a valid Q/C/V.

Function
REQ-014 SHALL decode OpCode as: 000 ASL, 001 ASR (sign-fill), 010 LSL, 011 LSR, 100 ROL, 101 ROR, 110/111 illegal.
REQ-015 SHALL implement FSM states IDLE, SHIFT, FIN; reset state is IDLE.
REQ-016 IDLE with START=1 and a legal OpCode and AMT>0 SHALL: load Q<=A, C<=0, V<=0, count<=AMT, and go to SHIFT.
REQ-017 IDLE with START=1 and AMT=0 SHALL: load Q<=A, C<=0, V<=0, and go to FIN.
REQ-018 IDLE with START=1 and an illegal OpCode SHALL: load Q<=0, C<=0, V<=0, and go to FIN.
REQ-019 Each SHIFT cycle SHALL apply one 1-bit step of the captured operation to Q and decrement count.
REQ-020 Each SHIFT cycle SHALL set C to the bit leaving Q: MSB for left shifts/rotates, LSB for right shifts/rotates.
REQ-021 On ASL, V SHALL set when Q[NBITS-1] differs before and after the step, and SHALL hold until the next accepted START.
REQ-022 The SHIFT state SHALL go to FIN on the cycle whose step makes count 0.
REQ-023 Latency SHALL be AMT+1 cycles from the accepted START edge to the DONE cycle.
REQ-024 FIN SHALL assert DONE for exactly one cycle and then return to IDLE.
REQ-025 Q, C and V SHALL hold their values in FIN and IDLE until the next accepted START.
REQ-026 START SHALL be ignored while in SHIFT or FIN, with no queuing.
REQ-027 A START held high SHALL be accepted again on the first IDLE cycle after FIN, which gives back-to-back operation.
REQ-028 AMT values of NBITS or more SHALL iterate fully, with no clamping.
REQ-029 With AMT of NBITS or more, logical shifts SHALL give Q=0, ASR SHALL give Q of all sign bits, and rotates SHALL give the result modulo NBITS.
REQ-030 A, OpCode and AMT changes after the accepted START SHALL have no effect on the operation in progress.

Reset
REQ-031 RST_N low SHALL, asynchronously: set state to IDLE, Q to 0, C to 0, V to 0, count to 0, BUSY to 0, DONE to 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation, and no DONE SHALL follow.
REQ-033 Reset deassertion SHALL take effect synchronously to CLK.
REQ-034 The first START SHALL be accepted on the first rising edge after deassertion.

Structure
REQ-035 The opcode constants (SH_ASL..SH_ROR) and the FSM state encoding SHALL live in shared package shifter_pkg.
REQ-036 The combinational 1-bit step SHALL be sub-module shift_step (inputs Q, op; outputs next Q, carry-out, sign-change).
REQ-037 The FSM, count and registers SHALL live in seq_shifter.

Verification (NBITS=8, AMTW=4)
REQ-038 ASL, A=0x41, AMT=1 SHALL give Q=0x82, C=0, V=1, with DONE 2 cycles after START.
REQ-039 ASR, A=0x90, AMT=3 SHALL give Q=0xF2, C=0, V=0, with DONE 4 cycles after START.
REQ-040 LSR, A=0xFF, AMT=8 SHALL give Q=0x00, C=1, and ROL, A=0x81, AMT=9 SHALL give Q=0x03, C=1.
REQ-041 ROR, A=0x01, AMT=0 SHALL give Q=0x01, C=0 with DONE 1 cycle later, and OpCode=111 SHALL give Q=0x00, C=0 with DONE 1 cycle later.
REQ-042 START pulsed during SHIFT SHALL be ignored, and START held high SHALL give back-to-back DONEs AMT+2 cycles apart.
REQ-043 RST_N pulsed low mid-SHIFT SHALL give immediately Q=0, C=0, V=0, BUSY=0, with no DONE.
